// File: rtl/ipic_mux_pkg.sv
// Shared definitions for the IPIC slave multiplexer: FSM encoding,
// timeout counter width and slave-index width helper.
package ipic_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_ERR     = 2'd2,
        ST_RELEASE = 2'd3
    } mux_state_t;

    // Wide enough for the largest legal timeout (1023 cycles).
    localparam int TMO_CNT_W = $clog2(1024);

    function automatic int sel_width(input int num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/ipic_addr_decode.sv
// Combinational base/mask window matcher; the lowest matching slave index wins.
module ipic_addr_decode
    import ipic_mux_pkg::*;
#(
    parameter int C_NUM_SLAVES = 4,
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_SEL_WIDTH  = sel_width(C_NUM_SLAVES),
    parameter logic [C_NUM_SLAVES*C_ADDR_WIDTH-1:0] C_SLAVE_BASE = {12'h700, 12'h600, 12'h400, 12'h200},
    parameter logic [C_NUM_SLAVES*C_ADDR_WIDTH-1:0] C_SLAVE_MASK = {12'hF00, 12'hF00, 12'hE00, 12'hE00}
) (
    input  logic [C_ADDR_WIDTH-1:0] addr,
    output logic                    hit,
    output logic [C_SEL_WIDTH-1:0]  index
);

    // Scan from the top down so a lower index overwrites any higher match.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = C_NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & C_SLAVE_MASK[i*C_ADDR_WIDTH +: C_ADDR_WIDTH]) ==
                (C_SLAVE_BASE[i*C_ADDR_WIDTH +: C_ADDR_WIDTH] & C_SLAVE_MASK[i*C_ADDR_WIDTH +: C_ADDR_WIDTH])) begin
                hit   = 1'b1;
                index = C_SEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/ipic_slave_mux.sv
// IPIC decoder/multiplexer: routes one bridge access to one of N register
// slaves and returns a single registered ack, with decode-miss and timeout errors.
module ipic_slave_mux
    import ipic_mux_pkg::*;
#(
    parameter int C_NUM_SLAVES     = 4,
    parameter int C_ADDR_WIDTH     = 12,
    parameter int C_DATA_WIDTH     = 32,
    parameter logic [C_NUM_SLAVES*C_ADDR_WIDTH-1:0] C_SLAVE_BASE = {12'h700, 12'h600, 12'h400, 12'h200},
    parameter logic [C_NUM_SLAVES*C_ADDR_WIDTH-1:0] C_SLAVE_MASK = {12'hF00, 12'hF00, 12'hE00, 12'hE00},
    parameter int C_TIMEOUT_CYCLES = 64
) (
    input  logic                                 bus2ip_clk,
    input  logic                                 bus2ip_resetn,
    input  logic [C_ADDR_WIDTH-1:0]              bus2ip_addr,
    input  logic                                 bus2ip_cs,
    input  logic                                 bus2ip_rdce,
    input  logic                                 bus2ip_wrce,
    output logic [C_NUM_SLAVES-1:0]              bus2ip_cs_int,
    output logic [C_NUM_SLAVES-1:0]              bus2ip_rdce_int,
    output logic [C_NUM_SLAVES-1:0]              bus2ip_wrce_int,
    input  logic [C_NUM_SLAVES-1:0]              slv_rdack,
    input  logic [C_NUM_SLAVES-1:0]              slv_wrack,
    input  logic [C_NUM_SLAVES-1:0]              slv_error,
    input  logic [C_NUM_SLAVES*C_DATA_WIDTH-1:0] slv_data,
    output logic                                 ip2bus_rdack,
    output logic                                 ip2bus_wrack,
    output logic                                 ip2bus_error,
    output logic [C_DATA_WIDTH-1:0]              ip2bus_data,
    output logic                                 timeout_evt,
    output logic                                 busy
);

    localparam int SEL_W = sel_width(C_NUM_SLAVES);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(C_TIMEOUT_CYCLES - 1);

    mux_state_t                state, state_nxt;
    logic [SEL_W-1:0]          sel, sel_nxt;
    logic                      is_read, is_read_nxt;
    logic [TMO_CNT_W-1:0]      cnt, cnt_nxt;
    logic [C_NUM_SLAVES-1:0]   cs_int_nxt, rdce_int_nxt, wrce_int_nxt;
    logic                      rdack_nxt, wrack_nxt, error_nxt, tmo_nxt;
    logic [C_DATA_WIDTH-1:0]   data_nxt;

    logic                      dec_hit;
    logic [SEL_W-1:0]          dec_index;
    logic [C_NUM_SLAVES-1:0]   onehot;
    logic                      ack_match;
    logic [C_DATA_WIDTH-1:0]   slv_data_arr [C_NUM_SLAVES];

    for (genvar g = 0; g < C_NUM_SLAVES; g++) begin : g_unpack
        assign slv_data_arr[g] = slv_data[g*C_DATA_WIDTH +: C_DATA_WIDTH];
    end

    ipic_addr_decode #(
        .C_NUM_SLAVES (C_NUM_SLAVES),
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_SEL_WIDTH  (SEL_W),
        .C_SLAVE_BASE (C_SLAVE_BASE),
        .C_SLAVE_MASK (C_SLAVE_MASK)
    ) u_decode (
        .addr  (bus2ip_addr),
        .hit   (dec_hit),
        .index (dec_index)
    );

    assign onehot    = {{(C_NUM_SLAVES-1){1'b0}}, 1'b1} << dec_index;
    assign ack_match = is_read ? slv_rdack[sel] : slv_wrack[sel];
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        is_read_nxt  = is_read;
        cnt_nxt      = cnt;
        cs_int_nxt   = bus2ip_cs_int;
        rdce_int_nxt = bus2ip_rdce_int;
        wrce_int_nxt = bus2ip_wrce_int;
        rdack_nxt    = 1'b0;
        wrack_nxt    = 1'b0;
        error_nxt    = 1'b0;
        tmo_nxt      = 1'b0;
        data_nxt     = '0;
        case (state)
            ST_IDLE: begin
                if (bus2ip_cs && (bus2ip_rdce || bus2ip_wrce)) begin
                    is_read_nxt = bus2ip_rdce;
                    cnt_nxt     = '0;
                    if ((bus2ip_rdce ^ bus2ip_wrce) && dec_hit) begin
                        sel_nxt      = dec_index;
                        cs_int_nxt   = onehot;
                        rdce_int_nxt = bus2ip_rdce ? onehot : '0;
                        wrce_int_nxt = bus2ip_wrce ? onehot : '0;
                        state_nxt    = ST_ACTIVE;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                // A slave ack in the expiry cycle takes priority over the timeout.
                if (ack_match) begin
                    rdack_nxt    = is_read;
                    wrack_nxt    = !is_read;
                    error_nxt    = slv_error[sel];
                    data_nxt     = is_read ? slv_data_arr[sel] : '0;
                    cs_int_nxt   = '0;
                    rdce_int_nxt = '0;
                    wrce_int_nxt = '0;
                    state_nxt    = ST_RELEASE;
                end else if (cnt == TMO_LAST) begin
                    rdack_nxt    = is_read;
                    wrack_nxt    = !is_read;
                    error_nxt    = 1'b1;
                    tmo_nxt      = 1'b1;
                    cs_int_nxt   = '0;
                    rdce_int_nxt = '0;
                    wrce_int_nxt = '0;
                    state_nxt    = ST_RELEASE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ERR: begin
                rdack_nxt = is_read;
                wrack_nxt = !is_read;
                error_nxt = 1'b1;
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus2ip_cs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_resetn) begin
        if (!bus2ip_resetn) begin
            state           <= ST_IDLE;
            sel             <= '0;
            is_read         <= 1'b0;
            cnt             <= '0;
            bus2ip_cs_int   <= '0;
            bus2ip_rdce_int <= '0;
            bus2ip_wrce_int <= '0;
            ip2bus_rdack    <= 1'b0;
            ip2bus_wrack    <= 1'b0;
            ip2bus_error    <= 1'b0;
            ip2bus_data     <= '0;
            timeout_evt     <= 1'b0;
        end else begin
            state           <= state_nxt;
            sel             <= sel_nxt;
            is_read         <= is_read_nxt;
            cnt             <= cnt_nxt;
            bus2ip_cs_int   <= cs_int_nxt;
            bus2ip_rdce_int <= rdce_int_nxt;
            bus2ip_wrce_int <= wrce_int_nxt;
            ip2bus_rdack    <= rdack_nxt;
            ip2bus_wrack    <= wrack_nxt;
            ip2bus_error    <= error_nxt;
            ip2bus_data     <= data_nxt;
            timeout_evt     <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_ipic_slave_mux.sv
// Scoreboard bench for ipic_slave_mux: expected responses (with their arrival
// cycle) are queued at request time and popped whenever the DUT acks.
module tb_ipic_slave_mux;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        err;
        logic [31:0] data;
        logic        tmo;
        int          cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn;
    int           cyc = 0;
    int           check_count = 0;
    int           error_count = 0;
    exp_t         sb[$];
    exp_t         e;
    int           t;

    // Main DUT: default windows, short timeout
    logic [11:0]  addr;
    logic         cs, rdce, wrce;
    logic [3:0]   cs_int, rdce_int, wrce_int;
    logic [3:0]   slv_rdack, slv_wrack, slv_error;
    logic [127:0] slv_data;
    logic         rdack, wrack, error, tmo, busy;
    logic [31:0]  data;

    // Second DUT: six slaves with overlapping windows at index 2 and 3
    logic [11:0]  addr2;
    logic         cs2, rdce2, wrce2;
    logic [5:0]   cs_int2, rdce_int2, wrce_int2;
    logic [5:0]   slv_rdack2, slv_wrack2, slv_error2;
    logic [191:0] slv_data2;
    logic         rdack2, wrack2, error2, tmo2, busy2;
    logic [31:0]  data2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ipic_slave_mux #(
        .C_NUM_SLAVES     (4),
        .C_ADDR_WIDTH     (12),
        .C_DATA_WIDTH     (32),
        .C_SLAVE_BASE     ({12'h700, 12'h600, 12'h400, 12'h200}),
        .C_SLAVE_MASK     ({12'hF00, 12'hF00, 12'hE00, 12'hE00}),
        .C_TIMEOUT_CYCLES (8)
    ) dut (
        .bus2ip_clk      (clk),
        .bus2ip_resetn   (resetn),
        .bus2ip_addr     (addr),
        .bus2ip_cs       (cs),
        .bus2ip_rdce     (rdce),
        .bus2ip_wrce     (wrce),
        .bus2ip_cs_int   (cs_int),
        .bus2ip_rdce_int (rdce_int),
        .bus2ip_wrce_int (wrce_int),
        .slv_rdack       (slv_rdack),
        .slv_wrack       (slv_wrack),
        .slv_error       (slv_error),
        .slv_data        (slv_data),
        .ip2bus_rdack    (rdack),
        .ip2bus_wrack    (wrack),
        .ip2bus_error    (error),
        .ip2bus_data     (data),
        .timeout_evt     (tmo),
        .busy            (busy)
    );

    ipic_slave_mux #(
        .C_NUM_SLAVES     (6),
        .C_ADDR_WIDTH     (12),
        .C_DATA_WIDTH     (32),
        .C_SLAVE_BASE     ({12'h900, 12'h800, 12'h400, 12'h400, 12'h200, 12'h100}),
        .C_SLAVE_MASK     ({12'hF00, 12'h800, 12'hF00, 12'hE00, 12'hE00, 12'hF00}),
        .C_TIMEOUT_CYCLES (8)
    ) dut6 (
        .bus2ip_clk      (clk),
        .bus2ip_resetn   (resetn),
        .bus2ip_addr     (addr2),
        .bus2ip_cs       (cs2),
        .bus2ip_rdce     (rdce2),
        .bus2ip_wrce     (wrce2),
        .bus2ip_cs_int   (cs_int2),
        .bus2ip_rdce_int (rdce_int2),
        .bus2ip_wrce_int (wrce_int2),
        .slv_rdack       (slv_rdack2),
        .slv_wrack       (slv_wrack2),
        .slv_error       (slv_error2),
        .slv_data        (slv_data2),
        .ip2bus_rdack    (rdack2),
        .ip2bus_wrack    (wrack2),
        .ip2bus_error    (error2),
        .ip2bus_data     (data2),
        .timeout_evt     (tmo2),
        .busy            (busy2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] a, input logic rd, input logic wr);
        tick();
        addr = a;
        cs   = 1'b1;
        rdce = rd;
        wrce = wr;
        t    = cyc;
    endtask

    task automatic endRequest();
        cs   = 1'b0;
        rdce = 1'b0;
        wrce = 1'b0;
    endtask

    // Every main-DUT ack must match the oldest queued expectation, on its cycle
    always @(negedge clk) begin
        if (rdack || wrack) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_ack", {62'd0, rdack, wrack}, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("ack_rd",    rdack, e.rd);
                checkOutput("ack_wr",    wrack, e.wr);
                checkOutput("ack_err",   error, e.err);
                checkOutput("ack_data",  data,  e.data);
                checkOutput("ack_tmo",   tmo,   e.tmo);
                checkOutput("ack_cycle", cyc,   e.cyc);
            end
        end else begin
            checkOutput("idle_data",  data,  64'd0);
            checkOutput("idle_tmo",   tmo,   64'd0);
            checkOutput("idle_error", error, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        addr = '0; cs = 0; rdce = 0; wrce = 0;
        slv_rdack = '0; slv_wrack = '0; slv_error = '0; slv_data = '0;
        addr2 = '0; cs2 = 0; rdce2 = 0; wrce2 = 0;
        slv_rdack2 = '0; slv_wrack2 = '0; slv_error2 = '0; slv_data2 = '0;
        #3;
        checkOutput("rst_cs_int", cs_int, 64'd0);
        checkOutput("rst_rdack",  rdack,  64'd0);
        checkOutput("rst_busy",   busy,   64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Read of config slave, slave acks three cycles after select
        applyStimulus(12'h404, 1'b1, 1'b0);
        sb.push_back('{rd: 1'b1, wr: 1'b0, err: 1'b0, data: 32'hDEADBEEF, tmo: 1'b0, cyc: t + 5});
        tick();
        checkOutput("rd_cs_int",   cs_int,   64'h2);
        checkOutput("rd_rdce_int", rdce_int, 64'h2);
        checkOutput("rd_wrce_int", wrce_int, 64'h0);
        repeat (3) tick();
        slv_rdack[1] = 1'b1;
        slv_data[63:32] = 32'hDEADBEEF;
        tick();
        slv_rdack = '0;
        slv_data = '0;
        checkOutput("rd_cs_int_clr", cs_int, 64'h0);
        checkOutput("rd_busy_rel",   busy,   64'h1);
        endRequest();
        tick();
        checkOutput("rd_busy_idle", busy, 64'h0);

        // Write to unmapped address
        applyStimulus(12'h1F0, 1'b0, 1'b1);
        sb.push_back('{rd: 1'b0, wr: 1'b1, err: 1'b1, data: 32'h0, tmo: 1'b0, cyc: t + 2});
        tick();
        checkOutput("miss_cs_int",   cs_int,   64'h0);
        checkOutput("miss_wrce_int", wrce_int, 64'h0);
        checkOutput("miss_busy",     busy,     64'h1);
        repeat (2) tick();
        checkOutput("miss_busy_held", busy, 64'h1);
        endRequest();
        tick();
        checkOutput("miss_busy_idle", busy, 64'h0);

        // Read to stats slave that never acks in time, then acks late
        applyStimulus(12'h210, 1'b1, 1'b0);
        sb.push_back('{rd: 1'b1, wr: 1'b0, err: 1'b1, data: 32'h0, tmo: 1'b1, cyc: t + 9});
        tick();
        checkOutput("tmo_cs_int", cs_int, 64'h1);
        repeat (10) tick();
        slv_rdack[0] = 1'b1;
        tick();
        slv_rdack = '0;
        checkOutput("tmo_cs_int_clr", cs_int, 64'h0);
        checkOutput("tmo_busy_rel",   busy,   64'h1);
        endRequest();
        tick();

        // Held write ack from slave 3 with spurious read acks alongside
        applyStimulus(12'h7A0, 1'b0, 1'b1);
        sb.push_back('{rd: 1'b0, wr: 1'b1, err: 1'b0, data: 32'h0, tmo: 1'b0, cyc: t + 3});
        tick();
        checkOutput("hold_wrce_int", wrce_int, 64'h8);
        slv_rdack = 4'b1001;
        tick();
        slv_rdack = '0;
        slv_wrack[3] = 1'b1;
        repeat (4) tick();
        slv_wrack = '0;
        endRequest();
        tick();

        // Reset in the middle of an active read, then a clean read with slave error
        applyStimulus(12'h600, 1'b1, 1'b0);
        repeat (2) tick();
        checkOutput("rst_mid_busy_before", busy, 64'h1);
        resetn = 1'b0;
        #1;
        checkOutput("rst_mid_cs_int",   cs_int,   64'h0);
        checkOutput("rst_mid_rdce_int", rdce_int, 64'h0);
        checkOutput("rst_mid_busy",     busy,     64'h0);
        endRequest();
        repeat (2) tick();
        resetn = 1'b1;
        applyStimulus(12'h600, 1'b1, 1'b0);
        sb.push_back('{rd: 1'b1, wr: 1'b0, err: 1'b1, data: 32'h12345678, tmo: 1'b0, cyc: t + 2});
        tick();
        checkOutput("post_rst_cs_int", cs_int, 64'h4);
        slv_rdack[2] = 1'b1;
        slv_error[2] = 1'b1;
        slv_data[95:64] = 32'h12345678;
        tick();
        slv_rdack = '0;
        slv_error = '0;
        slv_data = '0;
        endRequest();
        repeat (2) tick();

        // Overlapping windows on the six-slave instance
        tick();
        addr2 = 12'h420;
        cs2 = 1'b1;
        rdce2 = 1'b1;
        tick();
        checkOutput("ovl_cs_int",   cs_int2,   64'h04);
        checkOutput("ovl_rdce_int", rdce_int2, 64'h04);
        checkOutput("ovl_wrce_int", wrce_int2, 64'h00);
        slv_rdack2[2] = 1'b1;
        slv_data2[95:64] = 32'hCAFE0420;
        tick();
        slv_rdack2 = '0;
        slv_data2 = '0;
        checkOutput("ovl_rdack", rdack2, 64'h1);
        checkOutput("ovl_wrack", wrack2, 64'h0);
        checkOutput("ovl_error", error2, 64'h0);
        checkOutput("ovl_data",  data2,  64'hCAFE0420);
        checkOutput("ovl_tmo",   tmo2,   64'h0);
        cs2 = 1'b0;
        rdce2 = 1'b0;
        tick();
        checkOutput("ovl_busy_idle", busy2, 64'h0);

        repeat (2) tick();
        checkOutput("sb_empty", sb.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
